// File: rtl/serial_operand_tx.sv
// serial_operand_tx: bit-serial operand transmitter feeding a two-input bit-serial adder
//   clk          rising-edge clock
//   clear        asynchronous active-low reset
//   start        transfer request, sampled only while idle
//   a_in, b_in   parallel operands, captured on an accepted start
//   busy         high from the carry-clear cycle through the done cycle
//   s_a, s_b     serial operand bits, LSB first
//   shift_ctrl   high for exactly WIDTH cycles while bits are valid
//   carry_clr_n  active-low one-cycle clear for the downstream carry flop
//   done         one-cycle pulse after the last bit
module serial_operand_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             s_a,
  output logic             s_b,
  output logic             shift_ctrl,
  output logic             carry_clr_n,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, PREP, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        cnt_d   = '0;
        state_d = PREP;
      end
      PREP: state_d = SHIFT;
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Serial bits are gated so they read 0 outside SHIFT.
  assign busy        = state_q != IDLE;
  assign shift_ctrl  = state_q == SHIFT;
  assign s_a         = shift_ctrl & a_q[0];
  assign s_b         = shift_ctrl & b_q[0];
  assign carry_clr_n = state_q != PREP;
  assign done        = state_q == DONE;
endmodule
